// File: rtl/elevator_dispatcher.sv
// SCAN-policy request scheduler for one elevator car: latches calls, picks targets, times the door.
// Optional mid-travel retargeting is enabled by defining DISPATCH_RETARGET_EN.
module elevator_dispatcher #(
    parameter int DWELL_CYCLES    = 16,
    parameter int OVERTIME_CYCLES = 64
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] call,
    input  logic [7:0] cur_floor,
    input  logic       complete,
    input  logic       door_hold,
    output logic [7:0] request_floor,
    output logic       over_time,
    output logic       door_open,
    output logic [7:0] pending,
    output logic       busy,
    output logic       fault
);

    localparam int CW = $clog2(OVERTIME_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX   = '1;
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [CW-1:0] DWELL_LIM = CW'(DWELL_CYCLES);
    localparam logic [CW-1:0] OT_LIM    = CW'(OVERTIME_CYCLES);

    typedef enum logic [1:0] {
        S_IDLE,
        S_MOVE,
        S_DOOR,
        S_FAULT
    } state_e;

    state_e        state_q, state_d;
    logic [7:0]    request_floor_q, request_floor_d;
    logic [7:0]    pending_q, pending_d;
    logic          sweep_up_q, sweep_up_d;
    logic          door_open_q, door_open_d;
    logic          over_time_q, over_time_d;
    logic          busy_q, busy_d;
    logic          fault_q, fault_d;
    logic [CW-1:0] dwell_q, dwell_d;
    logic [CW-1:0] open_q, open_d;

    function automatic logic [7:0] lowest_bit(input logic [7:0] v);
        return v & (~v + 8'd1);
    endfunction

    function automatic logic [7:0] highest_bit(input logic [7:0] v);
        logic [7:0] r;
        r = '0;
        for (int i = 0; i < 8; i++) begin
            if (v[i]) begin
                r    = '0;
                r[i] = 1'b1;
            end
        end
        return r;
    endfunction

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_ONE;
    endfunction

    logic       floor_ok;
    logic [7:0] below_mask, above_mask, pend_above, pend_below;
    logic [7:0] tgt;
    logic       tgt_sweep_up;

    // Floor masks rely on cur_floor being one-hot; when it is not, the fault path overrides everything.
    assign floor_ok   = (cur_floor != 8'd0) && ((cur_floor & (cur_floor - 8'd1)) == 8'd0);
    assign below_mask = cur_floor - 8'd1;
    assign above_mask = ~(below_mask | cur_floor);
    assign pend_above = pending_q & above_mask;
    assign pend_below = pending_q & below_mask;

    always_comb begin
        tgt          = cur_floor;
        tgt_sweep_up = sweep_up_q;
        if ((pending_q & cur_floor) != 8'd0) begin
            tgt = cur_floor;
        end else if (sweep_up_q) begin
            if (pend_above != 8'd0) begin
                tgt = lowest_bit(pend_above);
            end else if (pend_below != 8'd0) begin
                tgt          = highest_bit(pend_below);
                tgt_sweep_up = 1'b0;
            end
        end else begin
            if (pend_below != 8'd0) begin
                tgt = highest_bit(pend_below);
            end else if (pend_above != 8'd0) begin
                tgt          = lowest_bit(pend_above);
                tgt_sweep_up = 1'b1;
            end
        end
    end

`ifdef DISPATCH_RETARGET_EN
    logic [7:0] retarget_win, retarget_tgt;

    // Only floors strictly ahead of the car and short of the current target qualify.
    always_comb begin
        if (sweep_up_q) begin
            retarget_win = pend_above & (request_floor_q - 8'd1);
            retarget_tgt = lowest_bit(retarget_win);
        end else begin
            retarget_win = pend_below & ~(request_floor_q | (request_floor_q - 8'd1));
            retarget_tgt = highest_bit(retarget_win);
        end
    end
`endif

    logic [7:0] call_eff, clr;

    // NOTE: every variable gets a default at the top so no path leaves it unassigned (no latches).
    always_comb begin
        state_d         = state_q;
        request_floor_d = request_floor_q;
        sweep_up_d      = sweep_up_q;
        door_open_d     = 1'b0;
        over_time_d     = 1'b0;
        fault_d         = fault_q;
        dwell_d         = '0;
        open_d          = '0;
        call_eff        = call;
        clr             = 8'd0;

        case (state_q)
            S_IDLE: begin
                request_floor_d = cur_floor;
                if (pending_q != 8'd0) begin
                    state_d         = S_MOVE;
                    request_floor_d = tgt;
                    sweep_up_d      = tgt_sweep_up;
                end
            end
            S_MOVE: begin
                if (complete && (cur_floor == request_floor_q)) begin
                    state_d     = S_DOOR;
                    clr         = cur_floor;
                    dwell_d     = CNT_ONE;
                    open_d      = CNT_ONE;
                    door_open_d = 1'b1;
                end
`ifdef DISPATCH_RETARGET_EN
                else if (retarget_win != 8'd0) begin
                    request_floor_d = retarget_tgt;
                end
`endif
            end
            S_DOOR: begin
                // A repeat call for the open floor is absorbed by keeping the door open longer.
                call_eff    = call & ~cur_floor;
                dwell_d     = sat_inc(dwell_q);
                open_d      = sat_inc(open_q);
                door_open_d = 1'b1;
                over_time_d = (open_d >= OT_LIM);
                if ((call & cur_floor) != 8'd0) begin
                    dwell_d = CNT_ONE;
                end else if ((dwell_q >= DWELL_LIM) && !door_hold) begin
                    dwell_d     = '0;
                    open_d      = '0;
                    door_open_d = 1'b0;
                    over_time_d = 1'b0;
                    if (pending_q != 8'd0) begin
                        state_d         = S_MOVE;
                        request_floor_d = tgt;
                        sweep_up_d      = tgt_sweep_up;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: begin
                state_d = S_FAULT;
            end
        endcase

        if (!floor_ok) begin
            state_d         = S_FAULT;
            request_floor_d = request_floor_q;
            sweep_up_d      = sweep_up_q;
            door_open_d     = 1'b0;
            over_time_d     = 1'b0;
            fault_d         = 1'b1;
            dwell_d         = '0;
            open_d          = '0;
            call_eff        = call;
            clr             = 8'd0;
        end

        pending_d = (pending_q | call_eff) & ~clr;
        busy_d    = (state_d == S_MOVE) || (state_d == S_DOOR);
    end

    // NOTE: sequential state uses non-blocking assignments only, so all flops update together.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= S_IDLE;
            request_floor_q <= 8'h01;
            pending_q       <= 8'h00;
            sweep_up_q      <= 1'b1;
            door_open_q     <= 1'b0;
            over_time_q     <= 1'b0;
            busy_q          <= 1'b0;
            fault_q         <= 1'b0;
            dwell_q         <= '0;
            open_q          <= '0;
        end else begin
            state_q         <= state_d;
            request_floor_q <= request_floor_d;
            pending_q       <= pending_d;
            sweep_up_q      <= sweep_up_d;
            door_open_q     <= door_open_d;
            over_time_q     <= over_time_d;
            busy_q          <= busy_d;
            fault_q         <= fault_d;
            dwell_q         <= dwell_d;
            open_q          <= open_d;
        end
    end

    assign request_floor = request_floor_q;
    assign pending       = pending_q;
    assign door_open     = door_open_q;
    assign over_time     = over_time_q;
    assign busy          = busy_q;
    assign fault         = fault_q;

endmodule

// File: tb/tb_elevator_dispatcher.sv
// Directed self-checking bench for elevator_dispatcher; expected values are hand-derived per scenario.
module tb_elevator_dispatcher;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] call;
    logic [7:0] cur_floor;
    logic       complete;
    logic       door_hold;
    logic [7:0] request_floor;
    logic       over_time;
    logic       door_open;
    logic [7:0] pending;
    logic       busy;
    logic       fault;

    int checks   = 0;
    int failures = 0;

    elevator_dispatcher #(
        .DWELL_CYCLES   (16),
        .OVERTIME_CYCLES(64)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .call         (call),
        .cur_floor    (cur_floor),
        .complete     (complete),
        .door_hold    (door_hold),
        .request_floor(request_floor),
        .over_time    (over_time),
        .door_open    (door_open),
        .pending      (pending),
        .busy         (busy),
        .fault        (fault)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance n rising edges and land 1 time unit after the last one.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Count door-open cycles from the current one; optionally re-press the open floor on cycle restart_at.
    task automatic measure_door(input int restart_at, input logic [7:0] floor, output int cnt);
        cnt = 0;
        while (door_open && cnt < 200) begin
            cnt++;
            call = (cnt == restart_at) ? floor : 8'h00;
            tick(1);
        end
        call = 8'h00;
    endtask

    int         n;
    logic [7:0] exp_req;

    initial begin
        reset     = 1'b1;
        call      = 8'h00;
        cur_floor = 8'h01;
        complete  = 1'b0;
        door_hold = 1'b0;
        tick(2);
        check("rst_request", 32'(request_floor), 32'h01);
        check("rst_pending", 32'(pending), 32'h00);
        check("rst_flags", {28'd0, door_open, over_time, busy, fault}, 32'h0);
        reset = 1'b0;
        tick(1);

        // Single call from floor 1 to floor 5.
        call = 8'h10;
        tick(1);
        call = 8'h00;
        check("t1_pending_set", 32'(pending), 32'h10);
        check("t1_idle_busy", 32'(busy), 32'h0);
        tick(1);
        check("t1_request", 32'(request_floor), 32'h10);
        check("t1_busy", 32'(busy), 32'h1);
        cur_floor = 8'h10;
        complete  = 1'b1;
        tick(1);
        complete = 1'b0;
        check("t1_door_open", 32'(door_open), 32'h1);
        check("t1_pending_clr", 32'(pending), 32'h00);
        measure_door(0, 8'h10, n);
        check("t1_dwell_len", 32'(n), 32'd16);
        check("t1_idle_after", 32'(busy), 32'h0);

        // SCAN: at floor 3 sweeping up, calls at top and bottom.
        cur_floor = 8'h04;
        tick(1);
        call = 8'h81;
        tick(1);
        call = 8'h00;
        tick(1);
        check("t2_first_tgt", 32'(request_floor), 32'h80);
        cur_floor = 8'h80;
        complete  = 1'b1;
        tick(1);
        complete = 1'b0;
        check("t2_pending_left", 32'(pending), 32'h01);
        tick(16);
        check("t2_second_tgt", 32'(request_floor), 32'h01);
        check("t2_moving", {30'd0, door_open, busy}, 32'h1);
        cur_floor = 8'h01;
        complete  = 1'b1;
        tick(1);
        complete = 1'b0;
        measure_door(0, 8'h01, n);
        check("t2_dwell_len", 32'(n), 32'd16);

        // Held door at floor 4: overtime, plus a same-floor call absorbed.
        call = 8'h08;
        tick(1);
        call = 8'h00;
        tick(1);
        check("t3_request", 32'(request_floor), 32'h08);
        cur_floor = 8'h08;
        complete  = 1'b1;
        door_hold = 1'b1;
        tick(1);
        complete = 1'b0;
        tick(62);
        check("t3_ot_cycle63", 32'(over_time), 32'h0);
        tick(1);
        check("t3_ot_cycle64", 32'(over_time), 32'h1);
        tick(6);
        call = 8'h08;
        tick(1);
        call = 8'h00;
        check("t3_no_latch", 32'(pending), 32'h00);
        tick(29);
        check("t3_still_open", {30'd0, door_open, over_time}, 32'h3);
        door_hold = 1'b0;
        tick(1);
        check("t3_exit", {29'd0, door_open, over_time, busy}, 32'h0);

        // Un-held door: same-floor call on open cycle 10 restarts the dwell.
        call = 8'h08;
        tick(1);
        call = 8'h00;
        tick(1);
        check("t4_request", 32'(request_floor), 32'h08);
        complete = 1'b1;
        tick(1);
        complete = 1'b0;
        measure_door(10, 8'h08, n);
        check("t4_dwell_restart", 32'(n), 32'd26);
        check("t4_pending", 32'(pending), 32'h00);

        // Call appearing mid-travel between the car and its target.
        cur_floor = 8'h01;
        tick(1);
        call = 8'h80;
        tick(1);
        call = 8'h00;
        tick(1);
        check("t5_request", 32'(request_floor), 32'h80);
        cur_floor = 8'h02;
        tick(1);
        call = 8'h08;
        tick(1);
        call = 8'h00;
        tick(1);
`ifdef DISPATCH_RETARGET_EN
        exp_req = 8'h08;
`else
        exp_req = 8'h80;
`endif
        check("t5_retarget", 32'(request_floor), 32'(exp_req));
        check("t5_pending3", 32'(pending[3]), 32'h1);
        tick(2);
        check("t5_req_stable", 32'(request_floor), 32'(exp_req));
        cur_floor = exp_req;
        complete  = 1'b1;
        tick(1);
        complete = 1'b0;
        check("t5_door", 32'(door_open), 32'h1);
        tick(3);

        // Reset while the door is open.
        reset     = 1'b1;
        cur_floor = 8'h04;
        tick(1);
        check("t6_rst_request", 32'(request_floor), 32'h01);
        check("t6_rst_pending", 32'(pending), 32'h00);
        check("t6_rst_flags", {28'd0, door_open, over_time, busy, fault}, 32'h0);
        reset     = 1'b0;
        cur_floor = 8'h01;
        tick(1);

        // Invalid floor encoding mid-move.
        call = 8'h10;
        tick(1);
        call = 8'h00;
        tick(1);
        check("t7_request", 32'(request_floor), 32'h10);
        cur_floor = 8'h00;
        tick(1);
        check("t7_fault", {29'd0, fault, door_open, busy}, 32'h4);
        check("t7_req_hold", 32'(request_floor), 32'h10);
        cur_floor = 8'h02;
        tick(3);
        check("t7_fault_sticky", {29'd0, fault, door_open, busy}, 32'h4);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        check("t7_fault_clr", 32'(fault), 32'h0);
        check("t7_rst_request", 32'(request_floor), 32'h01);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/elevator_dispatcher.md
# elevator_dispatcher

Request-side scheduler for the elevator controller: latches one-hot floor call buttons, picks the next target floor with a SCAN (sweep) policy, drives the controller's `request_floor`/`over_time` inputs, and consumes its `complete`/`out_current_floor` outputs. It also owns door dwell timing and door-overtime detection. The block sits between the car/hall button panel and the elevator controller, one instance per car.

## Interface

- `DWELL_CYCLES`, 16: cycles the door stays open on arrival (≥2).
- `OVERTIME_CYCLES`, 64: door-open cycles after which `over_time` asserts (> `DWELL_CYCLES`).
- `clk` input 1: clock; all logic on rising edge.
- `reset` input 1: synchronous, active-high.
- `call` input 8: one-hot-per-bit call pulses; several bits may be high at once.
- `cur_floor` input 8: controller `out_current_floor`; must be one-hot.
- `complete` input 1: controller arrival flag.
- `door_hold` input 1: door-obstruction or hold button; level.
- `request_floor` output 8: one-hot target to the controller.
- `over_time` output 1: door open too long; goes to the controller.
- `door_open` output 1: door command.
- `pending` output 8: latched unserved calls.
- `busy` output 1: high in MOVE or DOOR.
- `fault` output 1: `cur_floor` not one-hot; sticky.

## Operation

- **Reset values:** state IDLE, `request_floor`=8'h01, `pending`=0, sweep=up, `door_open`/`over_time`/`busy`/`fault`=0, counters 0.
- **Pending latch:** `pending <= (pending | call) & ~clr`.
  - `clr` is `cur_floor` on the cycle DOOR is entered. Otherwise it is 0.
  - A call for `cur_floor` while in DOOR is not latched. It restarts the dwell counter instead.
- **Target select, combinational from `pending` and `cur_floor`:**
  - Sweep up: take the lowest pending bit above `cur_floor`. If there is none, take the highest pending bit below `cur_floor` and flip sweep to down.
  - Sweep down: symmetric.
  - A pending bit equal to `cur_floor` selects the current floor.
- **FSM:**
  - IDLE
    - `request_floor <= cur_floor` every cycle.
    - If `pending`≠0, go to MOVE and load `request_floor` with the selected target.
  - MOVE
    - Hold `request_floor`.
    - When `complete`=1 and `cur_floor`==`request_floor`, go to DOOR.
  - DOOR
    - `door_open`=1 and the dwell counter counts up.
    - Exit when dwell ≥ `DWELL_CYCLES` and `door_hold`=0. Exit goes to MOVE with a new target if `pending`≠0, else to IDLE.
    - The open counter counts every DOOR cycle. `over_time`=1 once it reaches ≥ `OVERTIME_CYCLES`, and stays high until DOOR exits.
  - FAULT
    - Entered from any state when `cur_floor` is not one-hot (zero or multiple bits).
    - Outputs: `fault`=1, `request_floor` holds its last value, `door_open`=0.
    - Left only by `reset`.
- **Width rules:** both counters are `$clog2(OVERTIME_CYCLES+1)` bits and saturate; they never wrap.

## Timing

- A call in IDLE at edge t sets `pending` at t+1. The state is MOVE with a valid `request_floor` at t+2.
- Arrival sampled at edge t gives `door_open`=1 from t+1. `pending` clears at t+1.
- With `door_hold`=0 the door is open exactly `DWELL_CYCLES` cycles.
- `over_time` rises on the cycle the open count hits `OVERTIME_CYCLES`. It falls on the DOOR-exit edge.
- Call and `clr` on the same bit in the same cycle: the clear wins and the call is dropped, because that floor is being served.
- `reset` mid-MOVE or mid-DOOR: all state returns to reset values at the next edge and `pending` is lost.
- The `fault` check takes priority over every other transition in the same cycle.

## Configuration

- `DISPATCH_RETARGET_EN` defined:
  - In MOVE, a newly pending floor strictly between `cur_floor` and `request_floor`, in the current sweep direction, replaces `request_floor` on the next edge.
  - Retargeting is never allowed to a floor at or behind `cur_floor`.
- Undefined: `request_floor` is frozen from MOVE entry until arrival, and new calls wait in `pending`.

## Test plan

- Reset with `cur_floor`=8'h01, then pulse `call`=8'h10 → `request_floor`=8'h10 two cycles later; after `complete`, `door_open` high 16 cycles and `pending`=0.
- At floor 8'h04 sweeping up, pulse `call`=8'h81 → `request_floor`=8'h80 first, then 8'h01 with sweep down.
- In DOOR at 8'h08, hold `door_hold`=1 for 100 cycles → `over_time` rises at open-cycle 64, falls on exit; a call for 8'h08 during DOOR restarts the dwell and `pending[3]` stays 0.
- Force `cur_floor`=8'h00 mid-MOVE → `fault`=1 next cycle and sticky, `door_open`=0; `reset` clears it.
- MOVE from 8'h01 to 8'h80 with call 8'h08 injected while `cur_floor`=8'h02 → with `DISPATCH_RETARGET_EN`, `request_floor`=8'h08 next edge; without it, `request_floor` stays 8'h80 and `pending[3]`=1.
- Assert `reset` during DOOR → next cycle IDLE, `door_open`=0, `pending`=0, `request_floor`=8'h01.
